keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 144 ++++++++++++++
 tb/tb_keypad_scanner.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce and a one-deep event register
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-high reset
//   keyboard   row sense lines, active-low
//   column     column drive, active-low one-cold
//   counter    index of the driven column
//   key_code   hex code of the last accepted key
//   key_valid  key_code holds an unconsumed event
//   key_ack    consumer accepts the event while key_valid is high
//   overrun    sticky flag: an event was dropped while key_valid was high
module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] keyboard,
    input  logic       key_ack,
    output logic [3:0] column,
    output logic [1:0] counter,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       overrun
);
    localparam int DW = $clog2(SCAN_DIV + 1);
    localparam int BW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST = BW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t        state, state_n;
    logic [DW-1:0] dwell, dwell_n;
    logic [BW-1:0] deb, deb_n;
    logic [3:0]    pattern, pattern_n;
    logic [1:0]    row, row_n;
    logic [1:0]    counter_n;
    logic [3:0]    key_code_n;
    logic          key_valid_n, overrun_n;
    logic [3:0]    kb_n;
    logic          one_low, event_hit;

    assign column = ~(4'd1 << counter);
    assign kb_n = ~keyboard;
    // exactly one row pulled low
    assign one_low = (kb_n != 4'd0) && ((kb_n & (kb_n - 4'd1)) == 4'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= SCAN;
            dwell     <= '0;
            deb       <= '0;
            pattern   <= 4'hF;
            row       <= 2'd0;
            counter   <= 2'd0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            dwell     <= dwell_n;
            deb       <= deb_n;
            pattern   <= pattern_n;
            row       <= row_n;
            counter   <= counter_n;
            key_code  <= key_code_n;
            key_valid <= key_valid_n;
            overrun   <= overrun_n;
        end
    end

    always_comb begin
        state_n     = state;
        dwell_n     = dwell;
        deb_n       = deb;
        pattern_n   = pattern;
        row_n       = row;
        counter_n   = counter;
        key_code_n  = key_code;
        key_valid_n = key_valid;
        overrun_n   = overrun;
        event_hit   = 1'b0;
        case (state)
            SCAN: begin
                if (dwell == DWELL_LAST) begin
                    dwell_n = '0;
                    if (one_low) begin
                        state_n   = DEBOUNCE;
                        deb_n     = '0;
                        pattern_n = keyboard;
                        row_n     = !keyboard[0] ? 2'd0 : !keyboard[1] ? 2'd1 : !keyboard[2] ? 2'd2 : 2'd3;
                    end else begin
                        counter_n = counter + 2'd1;
                    end
                end else begin
                    dwell_n = dwell + DW'(1);
                end
            end
            DEBOUNCE: begin
                if (keyboard != pattern) begin
                    state_n   = SCAN;
                    dwell_n   = '0;
                    counter_n = counter + 2'd1;
                end else if (deb == DEB_LAST) begin
                    state_n   = HELD;
                    event_hit = 1'b1;
                end else begin
                    deb_n = deb + BW'(1);
                end
            end
            HELD: begin
                if (keyboard == 4'hF) begin
                    state_n = RELEASE;
                    deb_n   = '0;
                end
            end
            default: begin
                if (keyboard != 4'hF) begin
                    state_n = HELD;
                end else if (deb == DEB_LAST) begin
                    state_n   = SCAN;
                    dwell_n   = '0;
                    counter_n = counter + 2'd1;
                end else begin
                    deb_n = deb + BW'(1);
                end
            end
        endcase
        if (key_valid && key_ack) begin
            key_valid_n = 1'b0;
            overrun_n   = 1'b0;
        end
        // an ack in the same cycle frees the slot for the new event
        if (event_hit) begin
            if (!key_valid || key_ack) begin
                key_code_n  = {row, 2'b00} + {2'b00, counter} + 4'd1;
                key_valid_n = 1'b1;
            end else begin
                overrun_n = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=8
module tb_keypad_scanner;
    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] keyboard;
    logic       key_ack;
    logic [3:0] column;
    logic [1:0] counter;
    logic [3:0] key_code;
    logic       key_valid;
    logic       overrun;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] scan_cols [5] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
        .clock(clock),
        .reset(reset),
        .keyboard(keyboard),
        .key_ack(key_ack),
        .column(column),
        .counter(counter),
        .key_code(key_code),
        .key_valid(key_valid),
        .overrun(overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // wait for a fresh entry into column c, which lands on dwell 0
    task automatic wait_col(input logic [3:0] c);
        logic [3:0] prev;
        logic       hit;
        prev = column;
        hit = 1'b0;
        for (int i = 0; i < 64 && !hit; i++) begin
            @(negedge clock);
            if (column == c && prev != c) hit = 1'b1;
            prev = column;
        end
        check("wait_col", 8'(hit), 8'd1);
    endtask

    task automatic ack_pulse();
        key_ack = 1'b1;
        step(1);
        key_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        keyboard = 4'hF;
        key_ack = 1'b0;
        step(3);
        check("rst_column", 8'(column), 8'hE);
        check("rst_counter", 8'(counter), 8'd0);
        check("rst_code", 8'(key_code), 8'h0);
        check("rst_valid", 8'(key_valid), 8'd0);
        check("rst_overrun", 8'(overrun), 8'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("scan_column", 8'(column), 8'(scan_cols[i]));
            check("scan_counter", 8'(counter), 8'(i % 4));
            step(4);
        end
        // key 7: row1 in column 2
        wait_col(4'hB);
        keyboard = 4'b1101;
        step(11);
        check("k7_frozen", 8'(column), 8'hB);
        check("k7_pre_valid", 8'(key_valid), 8'd0);
        step(1);
        check("k7_valid", 8'(key_valid), 8'd1);
        check("k7_code", 8'(key_code), 8'h7);
        step(5);
        check("k7_held_col", 8'(column), 8'hB);
        check("k7_held_valid", 8'(key_valid), 8'd1);
        keyboard = 4'hF;
        step(8);
        check("k7_release_col", 8'(column), 8'hB);
        step(1);
        check("k7_resume_col", 8'(column), 8'h7);
        check("k7_valid_noack", 8'(key_valid), 8'd1);
        ack_pulse();
        check("k7_ack_valid", 8'(key_valid), 8'd0);
        // glitch on row0 in column 0
        wait_col(4'hE);
        keyboard = 4'b1110;
        step(5);
        check("glitch_frozen", 8'(column), 8'hE);
        step(1);
        keyboard = 4'hF;
        step(2);
        check("glitch_col", 8'(column), 8'hD);
        check("glitch_valid", 8'(key_valid), 8'd0);
        // key 0: row3 in column 3
        wait_col(4'h7);
        keyboard = 4'b0111;
        step(11);
        check("k0_pre_valid", 8'(key_valid), 8'd0);
        step(1);
        check("k0_valid", 8'(key_valid), 8'd1);
        check("k0_code", 8'(key_code), 8'h0);
        keyboard = 4'hF;
        step(9);
        check("k0_resume_col", 8'(column), 8'hE);
        ack_pulse();
        check("k0_ack_valid", 8'(key_valid), 8'd0);
        // two rows low never captures
        keyboard = 4'b1100;
        step(20);
        check("multi_valid", 8'(key_valid), 8'd0);
        check("multi_overrun", 8'(overrun), 8'd0);
        check("multi_col", 8'(column), 8'hD);
        keyboard = 4'hF;
        // key 1 then key 6 with no ack
        wait_col(4'hE);
        keyboard = 4'b1110;
        step(12);
        check("ov_k1_valid", 8'(key_valid), 8'd1);
        check("ov_k1_code", 8'(key_code), 8'h1);
        keyboard = 4'hF;
        step(9);
        keyboard = 4'b1101;
        step(12);
        check("ov_code", 8'(key_code), 8'h1);
        check("ov_overrun", 8'(overrun), 8'd1);
        check("ov_valid", 8'(key_valid), 8'd1);
        keyboard = 4'hF;
        step(9);
        ack_pulse();
        check("ov_ack_valid", 8'(key_valid), 8'd0);
        check("ov_ack_overrun", 8'(overrun), 8'd0);
        // build valid+overrun, then ack coincident with key 6
        wait_col(4'h7);
        keyboard = 4'b0111;
        step(12);
        keyboard = 4'hF;
        step(9);
        keyboard = 4'b1110;
        step(12);
        check("co_pre_overrun", 8'(overrun), 8'd1);
        keyboard = 4'hF;
        step(9);
        keyboard = 4'b1101;
        step(11);
        check("co_pre_code", 8'(key_code), 8'h0);
        ack_pulse();
        check("co_valid", 8'(key_valid), 8'd1);
        check("co_code", 8'(key_code), 8'h6);
        check("co_overrun", 8'(overrun), 8'd0);
        // reset in the fifth debounce cycle of key B
        keyboard = 4'hF;
        step(9);
        keyboard = 4'b1011;
        step(8);
        reset = 1'b1;
        #1;
        check("ar_column", 8'(column), 8'hE);
        check("ar_counter", 8'(counter), 8'd0);
        check("ar_valid", 8'(key_valid), 8'd0);
        check("ar_code", 8'(key_code), 8'h0);
        check("ar_overrun", 8'(overrun), 8'd0);
        step(2);
        keyboard = 4'hF;
        reset = 1'b0;
        check("ar_rel_column", 8'(column), 8'hE);
        step(4);
        check("ar_scan_column", 8'(column), 8'hD);
        check("ar_no_event", 8'(key_valid), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
